// File: rtl/id_stage_sb.sv
// Decode stage: register read, per-register scoreboard, valid/ready issue to EX.
// Optional macro WB_BYPASS_EN: same-cycle write-back clears hazards and forwards data.
module id_stage_sb #(
    parameter int W_DATA = 32,
    parameter int W_PC   = 16,
    parameter int N_REG  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid_i,
    output logic              id_ready_o,
    input  logic [31:0]       inst_i,
    input  logic [W_PC-1:0]   pc_value_i,
    input  logic              flush_i,
    output logic              ex_valid_o,
    input  logic              ex_ready_i,
    output logic [6:0]        ctrl_o,
    output logic              illegal_o,
    output logic              immf_o,
    output logic [W_DATA-1:0] rd_value_o,
    output logic [W_DATA-1:0] rs_value_o,
    output logic [W_DATA-1:0] imm_value_o,
    output logic [6:0]        opcode_o,
    output logic [3:0]        rd_addr_o,
    output logic [W_PC-1:0]   pc_value_o,
    input  logic              wb_i,
    input  logic [3:0]        wb_r_i,
    input  logic [W_DATA-1:0] wb_data_i
);

    localparam logic [6:0] C_INTE  = 7'b1000000;
    localparam logic [6:0] C_LOGIC = 7'b0100000;
    localparam logic [6:0] C_SHIFT = 7'b0010000;
    localparam logic [6:0] C_LD    = 7'b0001000;
    localparam logic [6:0] C_ST    = 7'b0000100;
    localparam logic [6:0] C_BR    = 7'b0000010;
    localparam logic [6:0] C_SET   = 7'b0000001;

    typedef struct packed {
        logic [6:0]        ctrl;
        logic              illegal;
        logic              immf;
        logic [W_DATA-1:0] rd_value;
        logic [W_DATA-1:0] rs_value;
        logic [W_DATA-1:0] imm_value;
        logic [6:0]        opcode;
        logic [3:0]        rd_addr;
        logic [W_PC-1:0]   pc;
    } bundle_t;

    function automatic logic in_rng(input logic [3:0] a);
        return {28'd0, a} < 32'(N_REG);
    endfunction

    logic [6:0]        opcode;
    logic              immf;
    logic [3:0]        rd;
    logic [3:0]        rs;
    logic [15:0]       imm;
    logic [6:0]        ctrl;
    logic              writes_rd;
    logic [W_DATA-1:0] imm_ext;

    logic [W_DATA-1:0] rf_q [N_REG];
    logic [N_REG-1:0]  sb_q;
    logic [N_REG-1:0]  sb_eff;
    logic [N_REG-1:0]  wb_mask;
    logic [N_REG-1:0]  set_mask;

    logic              rd_ok;
    logic              rs_ok;
    logic              wb_ok;
    logic [W_DATA-1:0] rd_val;
    logic [W_DATA-1:0] rs_val;
    logic              hazard;
    logic              fire_in;

    bundle_t           bnd_q;
    bundle_t           bnd_d;
    logic              valid_q;

    assign opcode = inst_i[31:25];
    assign immf   = inst_i[24];
    assign rd     = inst_i[23:20];
    assign rs     = inst_i[19:16];
    assign imm    = inst_i[15:0];

    assign rd_ok  = in_rng(rd);
    assign rs_ok  = in_rng(rs);
    assign wb_ok  = wb_i & in_rng(wb_r_i);

    // Opcode class decode; anything unmatched is illegal with ctrl zero
    always_comb begin
        ctrl = '0;
        unique case (1'b1)
            (opcode inside {[7'h00:7'h07]}):               ctrl = C_INTE;
            (opcode inside {[7'h08:7'h0A], 7'h0C, 7'h0D}): ctrl = C_SHIFT;
            (opcode inside {[7'h10:7'h13]}):               ctrl = C_LOGIC;
            (opcode inside {7'h16, 7'h17}):                ctrl = C_SET;
            (opcode == 7'h18):                             ctrl = C_LD;
            (opcode == 7'h19):                             ctrl = C_ST;
            (opcode inside {[7'h1C:7'h1F]}):               ctrl = C_BR;
            default:                                       ctrl = '0;
        endcase
    end

    // Destination reservation and immediate extension by class
    always_comb begin
        writes_rd = ctrl[6] & (opcode != 7'h04);
        writes_rd = writes_rd | ctrl[5] | ctrl[4];
        writes_rd = writes_rd | ctrl[3] | ctrl[0];
        if (ctrl[4]) begin
            imm_ext = W_DATA'(imm);
        end else begin
            imm_ext = W_DATA'(signed'(imm));
        end
    end

    // One-hot masks for write-back clear and issue-time reservation
    always_comb begin
        wb_mask  = '0;
        set_mask = '0;
        if (wb_ok) begin
            wb_mask[wb_r_i] = 1'b1;
        end
        if (fire_in && writes_rd && rd_ok) begin
            set_mask[rd] = 1'b1;
        end
    end

    // Operand read and hazard view, with optional same-cycle bypass
    always_comb begin
        rd_val = rd_ok ? rf_q[rd] : '0;
        rs_val = rs_ok ? rf_q[rs] : '0;
`ifdef WB_BYPASS_EN
        sb_eff = sb_q & ~wb_mask;
        if (wb_ok && (wb_r_i == rd)) begin
            rd_val = wb_data_i;
        end
        if (wb_ok && (wb_r_i == rs)) begin
            rs_val = wb_data_i;
        end
`else
        sb_eff = sb_q;
`endif
        hazard = 1'b0;
        if (if_valid_i) begin
            hazard = (rd_ok & sb_eff[rd]) | (rs_ok & sb_eff[rs]);
        end
    end

    assign id_ready_o = ~hazard & (~valid_q | ex_ready_i);
    assign fire_in    = if_valid_i & id_ready_o & ~flush_i;

    // Next output bundle assembled from the current instruction
    always_comb begin
        bnd_d           = '0;
        bnd_d.ctrl      = ctrl;
        bnd_d.illegal   = ~|ctrl;
        bnd_d.immf      = immf;
        bnd_d.rd_value  = rd_val;
        bnd_d.rs_value  = rs_val;
        bnd_d.imm_value = imm_ext;
        bnd_d.opcode    = opcode;
        bnd_d.rd_addr   = rd;
        bnd_d.pc        = pc_value_i;
    end

    // Output register: load on accept, hold under back-pressure, drop on flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            bnd_q   <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (fire_in) begin
            valid_q <= 1'b1;
            bnd_q   <= bnd_d;
        end else if (valid_q && ex_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    // Scoreboard: write-back clears, issue reserves; reservation wins a tie
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb_q <= '0;
        end else begin
            sb_q <= (sb_q & ~wb_mask) | set_mask;
        end
    end

    // Register file write port driven by write-back
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_REG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_ok) begin
            rf_q[wb_r_i] <= wb_data_i;
        end
    end

    assign ex_valid_o  = valid_q;
    assign ctrl_o      = bnd_q.ctrl;
    assign illegal_o   = bnd_q.illegal;
    assign immf_o      = bnd_q.immf;
    assign rd_value_o  = bnd_q.rd_value;
    assign rs_value_o  = bnd_q.rs_value;
    assign imm_value_o = bnd_q.imm_value;
    assign opcode_o    = bnd_q.opcode;
    assign rd_addr_o   = bnd_q.rd_addr;
    assign pc_value_o  = bnd_q.pc;

endmodule

// File: tb/tb_id_stage_sb.sv
// Scoreboard bench for id_stage_sb: driver queues expected bundles,
// a negedge monitor pops and compares on each EX handshake.
module tb_id_stage_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid_i;
    logic        id_ready_o;
    logic [31:0] inst_i;
    logic [15:0] pc_value_i;
    logic        flush_i;
    logic        ex_valid_o;
    logic        ex_ready_i;
    logic [6:0]  ctrl_o;
    logic        illegal_o;
    logic        immf_o;
    logic [31:0] rd_value_o;
    logic [31:0] rs_value_o;
    logic [31:0] imm_value_o;
    logic [6:0]  opcode_o;
    logic [3:0]  rd_addr_o;
    logic [15:0] pc_value_o;
    logic        wb_i;
    logic [3:0]  wb_r_i;
    logic [31:0] wb_data_i;

    typedef struct packed {
        logic [6:0]  ctrl;
        logic        illegal;
        logic        immf;
        logic [31:0] rd_value;
        logic [31:0] rs_value;
        logic [31:0] imm_value;
        logic [6:0]  opcode;
        logic [3:0]  rd_addr;
        logic [15:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   waited;

    id_stage_sb dut (
        .clk(clk), .rst(rst),
        .if_valid_i(if_valid_i), .id_ready_o(id_ready_o),
        .inst_i(inst_i), .pc_value_i(pc_value_i),
        .flush_i(flush_i),
        .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
        .ctrl_o(ctrl_o), .illegal_o(illegal_o), .immf_o(immf_o),
        .rd_value_o(rd_value_o), .rs_value_o(rs_value_o),
        .imm_value_o(imm_value_o), .opcode_o(opcode_o),
        .rd_addr_o(rd_addr_o), .pc_value_o(pc_value_o),
        .wb_i(wb_i), .wb_r_i(wb_r_i), .wb_data_i(wb_data_i)
    );

    always #5 clk = ~clk;

    function automatic exp_t dut_b();
        return exp_t'({ctrl_o, illegal_o, immf_o, rd_value_o, rs_value_o,
                       imm_value_o, opcode_o, rd_addr_o, pc_value_o});
    endfunction

    function automatic logic [31:0] ins(input logic [6:0] op, input logic f,
                                        input logic [3:0] d, input logic [3:0] s,
                                        input logic [15:0] im);
        return {op, f, d, s, im};
    endfunction

    function automatic exp_t mk(input logic [6:0] c, input logic il,
                                input logic f, input logic [31:0] rv,
                                input logic [31:0] sv, input logic [31:0] im,
                                input logic [6:0] op, input logic [3:0] d,
                                input logic [15:0] pc);
        exp_t e;
        e = '{c, il, f, rv, sv, im, op, d, pc};
        return e;
    endfunction

    task automatic chk(input string nm, input logic [159:0] got,
                       input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [3:0] r, input logic [31:0] d);
        wb_i = 1'b1; wb_r_i = r; wb_data_i = d;
        tick();
        wb_i = 1'b0;
    endtask

    // Present an instruction until the DUT is ready; queue its expectation
    task automatic issue(input logic [31:0] inst, input logic [15:0] pc,
                         input exp_t e, output int w);
        bit done;
        done = 1'b0;
        w = 0;
        inst_i = inst; pc_value_i = pc; if_valid_i = 1'b1;
        while (!done && w <= 20) begin
            @(negedge clk);
            if (id_ready_o) begin
                exp_q.push_back(e);
                tick();
                done = 1'b1;
            end else begin
                tick();
                w++;
            end
        end
        if_valid_i = 1'b0;
        if (!done) begin
            w = -1;
            checks++;
            errors++;
            $display("FAIL issue_timeout got=not_ready exp=ready");
        end
    endtask

    // Dependent instruction stalls until write-back of register r
    task automatic hazard_release(input logic [31:0] inst,
                                  input logic [15:0] pc, input exp_t e,
                                  input logic [3:0] r, input logic [31:0] d);
        inst_i = inst; pc_value_i = pc; if_valid_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("haz_stall", id_ready_o, 0);
            tick();
        end
        wb_i = 1'b1; wb_r_i = r; wb_data_i = d;
        @(negedge clk);
`ifdef WB_BYPASS_EN
        chk("haz_byp_ready", id_ready_o, 1);
        exp_q.push_back(e);
        tick();
        wb_i = 1'b0;
`else
        chk("haz_wb_cycle_stall", id_ready_o, 0);
        tick();
        wb_i = 1'b0;
        @(negedge clk);
        chk("haz_next_ready", id_ready_o, 1);
        exp_q.push_back(e);
        tick();
`endif
        if_valid_i = 1'b0;
    endtask

    // Monitor: every EX handshake consumes one expected bundle
    always @(negedge clk) begin
        exp_t e;
        if (rst && ex_valid_o && ex_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bundle got=%0h exp=none", dut_b());
            end else begin
                e = exp_q.pop_front();
                chk("bundle", dut_b(), e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t eA, eB, eC, eD, eE, eF, eG, eI, eK, eL, eM, eN;
        logic [31:0] rk;

        rst = 1'b0; if_valid_i = 1'b0; inst_i = '0; pc_value_i = '0;
        flush_i = 1'b0; ex_ready_i = 1'b0;
        wb_i = 1'b0; wb_r_i = '0; wb_data_i = '0;

        @(negedge clk);
        chk("rst_outputs", {ex_valid_o, dut_b()}, '0);
        chk("rst_id_ready", id_ready_o, 1);
        tick();
        rst = 1'b1;

        wb(4'd7, 32'h1234_5678);
        wb(4'd2, 32'hA5A5_0001);

        // Basic issue and latency
        ex_ready_i = 1'b1;
        eA = mk(7'b1000000, 0, 1, 0, 0, 32'h12, 7'h00, 3, 16'h0100);
        issue(ins(7'h00, 1, 3, 4, 16'h0012), 16'h0100, eA, waited);
        chk("t1_wait", waited, 0);
        @(negedge clk);
        chk("t1_latency", ex_valid_o, 1);
        tick();

        // RAW on r3 released by write-back of 0x55
        eB = mk(7'b0100000, 0, 0, 0, 32'h55, 32'hFFFF_FFFF, 7'h10, 6,
                16'h0104);
        hazard_release(ins(7'h10, 0, 6, 3, 16'hFFFF), 16'h0104, eB,
                       4'd3, 32'h55);
        tick();

        // Back-pressure: shift bundle held three cycles
        ex_ready_i = 1'b0;
        eC = mk(7'b0010000, 0, 1, 0, 32'h1234_5678, 32'h0000_8000, 7'h08, 8,
                16'h0108);
        issue(ins(7'h08, 1, 8, 7, 16'h8000), 16'h0108, eC, waited);
        chk("t3_wait", waited, 0);
        inst_i = ins(7'h01, 0, 9, 2, 16'h8000);
        pc_value_i = 16'h010C;
        if_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_ready", id_ready_o, 0);
            chk("stall_valid", ex_valid_o, 1);
            chk("stall_hold", dut_b(), eC);
            tick();
        end
        ex_ready_i = 1'b1;
        eD = mk(7'b1000000, 0, 0, 0, 32'hA5A5_0001, 32'hFFFF_8000, 7'h01, 9,
                16'h010C);
        issue(ins(7'h01, 0, 9, 2, 16'h8000), 16'h010C, eD, waited);
        chk("t3_release", waited, 0);

        // Illegal opcode reserves nothing
        eE = mk(7'b0000000, 1, 0, 0, 0, 32'h1234, 7'h7F, 10, 16'h0110);
        issue(ins(7'h7F, 0, 10, 0, 16'h1234), 16'h0110, eE, waited);
        chk("illegal_wait", waited, 0);
        eF = mk(7'b0000100, 0, 1, 0, 0, 32'h7FFF, 7'h19, 10, 16'h0114);
        issue(ins(7'h19, 1, 10, 10, 16'h7FFF), 16'h0114, eF, waited);
        chk("illegal_no_sb", waited, 0);

        // Flush drops the held bundle and blocks an incoming one
        eG = mk(7'b0000010, 0, 0, 0, 0, 32'hFFFF_FFF0, 7'h1C, 0, 16'h0118);
        issue(ins(7'h1C, 0, 0, 1, 16'hFFF0), 16'h0118, eG, waited);
        ex_ready_i = 1'b0;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        @(negedge clk);
        chk("flush_drop", ex_valid_o, 0);
        void'(exp_q.pop_back());
        tick();
        ex_ready_i = 1'b1;
        flush_i = 1'b1;
        inst_i = ins(7'h02, 0, 11, 0, 16'h0000);
        pc_value_i = 16'h011C;
        if_valid_i = 1'b1;
        tick();
        flush_i = 1'b0;
        if_valid_i = 1'b0;
        @(negedge clk);
        chk("flush_block", ex_valid_o, 0);
        tick();
        eI = mk(7'b0100000, 0, 0, 0, 0, 32'h1, 7'h13, 12, 16'h0120);
        issue(ins(7'h13, 0, 12, 11, 16'h0001), 16'h0120, eI, waited);
        chk("flush_no_sb", waited, 0);

        // Reservation and write-back of r5 in the same cycle
`ifdef WB_BYPASS_EN
        rk = 32'h77;
`else
        rk = 32'h0;
`endif
        eK = mk(7'b0000001, 0, 0, rk, 0, 32'h100, 7'h16, 5, 16'h0124);
        wb_i = 1'b1; wb_r_i = 4'd5; wb_data_i = 32'h77;
        issue(ins(7'h16, 0, 5, 0, 16'h0100), 16'h0124, eK, waited);
        wb_i = 1'b0;
        chk("setwin_wait", waited, 0);
        eL = mk(7'b0100000, 0, 0, 0, 32'h99, 32'h2, 7'h11, 13, 16'h0128);
        hazard_release(ins(7'h11, 0, 13, 5, 16'h0002), 16'h0128, eL,
                       4'd5, 32'h99);

        // Asynchronous reset while a bundle is stalled
        eM = mk(7'b1000000, 0, 0, 0, 32'h1234_5678, 32'h0, 7'h05, 14,
                16'h012C);
        issue(ins(7'h05, 0, 14, 7, 16'h0000), 16'h012C, eM, waited);
        ex_ready_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_async_out", {ex_valid_o, dut_b()}, '0);
        chk("rst_async_ready", id_ready_o, 1);
        void'(exp_q.pop_back());
        tick();
        rst = 1'b1;
        ex_ready_i = 1'b1;
        eN = mk(7'b0100000, 0, 0, 0, 0, 32'hAB, 7'h12, 6, 16'h0130);
        issue(ins(7'h12, 0, 6, 7, 16'h00AB), 16'h0130, eN, waited);
        chk("rst_sb_clear", waited, 0);

        repeat (3) tick();
        chk("drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
